a_io_m_axi_write_arbiter: RTL and testbench
===========================================

Name: a_io_m_axi_write_arbiter

Overview:
- Shares one AXI write master (AW + W) among NUM_PORTS write requesters, for example several serialize/throttle front-ends feeding one m_axi bus.
- Round-robin arbitration is done per AW request.
- The granted port index is queued in issue order, and the W channel is steered to the port at the queue head until its WLAST beat completes.
- The block sits between the requester-side throttles and the bus-side register slice.

Parameters:
- NUM_PORTS, 2, number of requesters (2..8).
- ADDR_WIDTH, 32, AWADDR width.
- DATA_WIDTH, 32, WDATA width; WSTRB width is DATA_WIDTH/8.
- MAXREQS, 4, depth of the order queue (power of 2); maximum granted bursts whose data is still pending.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- clk_en  in  1  state-update enable; when low, all registers hold
- in_TOP_AWADDR  in  NUM_PORTS*ADDR_WIDTH  per-port address, port i at slice i
- in_TOP_AWLEN  in  NUM_PORTS*8  per-port burst length minus 1
- in_TOP_AWVALID  in  NUM_PORTS  per-port AW valid
- out_TOP_AWREADY  out  NUM_PORTS  per-port AW ready
- in_TOP_WDATA  in  NUM_PORTS*DATA_WIDTH  per-port write data
- in_TOP_WSTRB  in  NUM_PORTS*DATA_WIDTH/8  per-port strobes
- in_TOP_WLAST  in  NUM_PORTS  per-port last beat
- in_TOP_WVALID  in  NUM_PORTS  per-port W valid
- out_TOP_WREADY  out  NUM_PORTS  per-port W ready
- out_BUS_AWADDR  out  ADDR_WIDTH  bus address (registered)
- out_BUS_AWLEN  out  8  bus burst length (registered)
- out_BUS_AWVALID  out  1  bus AW valid (registered)
- in_BUS_AWREADY  in  1  bus AW ready
- out_BUS_WDATA  out  DATA_WIDTH  bus write data (muxed)
- out_BUS_WSTRB  out  DATA_WIDTH/8  bus strobes (muxed)
- out_BUS_WLAST  out  1  bus last beat (muxed)
- out_BUS_WVALID  out  1  bus W valid
- in_BUS_WREADY  in  1  bus W ready

Behaviour:
- Reset values:
  - state IDLE; order queue empty.
  - last_grant = NUM_PORTS-1, so port 0 wins first.
  - out_BUS_AWVALID 0, out_BUS_WVALID 0, all out_TOP_AWREADY and out_TOP_WREADY 0.
  - out_BUS_AWADDR/AWLEN 0.
- AW FSM, state IDLE:
  - sel = first i with in_TOP_AWVALID[i], searching (last_grant+1) mod NUM_PORTS upward with wrap.
  - If any valid and queue not full: out_TOP_AWREADY[sel]=1 (combinational); all others 0.
  - On clk_en, capture that port's ADDR/LEN into the output registers, push sel to the queue, set last_grant=sel, go to ISSUE.
  - If the queue is full: all AWREADY 0 and the FSM stays in IDLE.
- AW FSM, state ISSUE:
  - out_BUS_AWVALID=1 with stable ADDR/LEN; all out_TOP_AWREADY 0.
  - On in_BUS_AWREADY & clk_en, go to IDLE.
  - Latency is 1 cycle minimum from TOP handshake to BUS AWVALID; at most one AW accepted per 2 cycles.
- W steering:
  - If the queue is empty: out_BUS_WVALID=0, all out_TOP_WREADY 0, and bus W data/strb/last are driven 0.
  - Otherwise, with h = queue head: out_BUS_W* = port h's W signals; out_TOP_WREADY[h]=in_BUS_WREADY; other ports get WREADY 0.
  - W data for a port may start once its AW has been pushed; it does not wait for the bus AW handshake.
- Queue pop: on out_BUS_WVALID & in_BUS_WREADY & out_BUS_WLAST & clk_en.
  - Simultaneous push and pop leave the count unchanged; push while full is impossible because AWREADY is blocked.
  - Count width is log2(MAXREQS)+1; pointers wrap modulo MAXREQS.
- Reset during operation: the outstanding AW and all queued indices are discarded, and all outputs return to reset values the next cycle.
- clk_en low: FSM, queue and last_grant hold. Combinational readies still reflect the current state, but no capture or pop occurs.

Optional Feature:
- Macro A_IO_M_AXI_WARB_PRIO0_EN.
- Defined: port 0 has strict priority; sel = the lowest-index valid port, and last_grant is ignored.
- Undefined: round-robin as described above.
- W steering and queue behaviour are identical in both cases.

Test Plan:
- Reset, then ports 0 and 1 both assert AWVALID (addr 0x100/0x200, len 3) with BUS AWREADY=1 -> grants in order port0 then port1; BUS AWADDR sequence 0x100, 0x200; queue holds {0,1}.
- Continue with port1's W beats presented before port0's -> port1 WREADY stays 0 until port0's WLAST beat (4th beat) completes; then 4 beats of port1 pass; queue empties.
- MAXREQS=4, BUS WREADY=0, four AW grants -> 5th AWVALID sees AWREADY=0 until one WLAST pop.
- Holding in_BUS_AWREADY=0 for 5 cycles in ISSUE -> AWVALID/ADDR/LEN stable; no new TOP AWREADY.
- Assert reset mid-burst (2 of 4 beats sent) -> next cycle all outputs 0, queue empty, port 0 wins the next arbitration.
- With A_IO_M_AXI_WARB_PRIO0_EN, port 0 AWVALID held continuously while port 1 waits -> only port 0 granted; without the macro, grants alternate 0, 1, 0, 1.

Source files
------------

// File: rtl/a_io_m_axi_write_arbiter.sv
// rtl/a_io_m_axi_write_arbiter.sv - round-robin AW arbiter with in-order W steering for one AXI write master
// Optional A_IO_M_AXI_WARB_PRIO0_EN: port 0 gets strict priority instead of round-robin.
module a_io_m_axi_write_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAXREQS    = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              clk_en,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   in_TOP_AWADDR,
  input  logic [NUM_PORTS*8-1:0]            in_TOP_AWLEN,
  input  logic [NUM_PORTS-1:0]              in_TOP_AWVALID,
  output logic [NUM_PORTS-1:0]              out_TOP_AWREADY,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   in_TOP_WDATA,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] in_TOP_WSTRB,
  input  logic [NUM_PORTS-1:0]              in_TOP_WLAST,
  input  logic [NUM_PORTS-1:0]              in_TOP_WVALID,
  output logic [NUM_PORTS-1:0]              out_TOP_WREADY,
  output logic [ADDR_WIDTH-1:0]             out_BUS_AWADDR,
  output logic [7:0]                        out_BUS_AWLEN,
  output logic                              out_BUS_AWVALID,
  input  logic                              in_BUS_AWREADY,
  output logic [DATA_WIDTH-1:0]             out_BUS_WDATA,
  output logic [DATA_WIDTH/8-1:0]           out_BUS_WSTRB,
  output logic                              out_BUS_WLAST,
  output logic                              out_BUS_WVALID,
  input  logic                              in_BUS_WREADY
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam int SW    = DATA_WIDTH / 8;
  localparam int PTR_W = $clog2(MAXREQS);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [IDX_W-1:0]        r_last_grant;
  logic [ADDR_WIDTH-1:0]   r_awaddr;
  logic [7:0]              r_awlen;
  logic [IDX_W-1:0]        r_q [MAXREQS];
  logic [PTR_W-1:0]        r_wptr;
  logic [PTR_W-1:0]        r_rptr;
  logic [CNT_W-1:0]        r_count;

  logic [IDX_W-1:0]        w_sel;
  logic                    w_any;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;
  logic [IDX_W-1:0]        w_head;

  assign w_full  = (r_count == CNT_W'(MAXREQS));
  assign w_empty = (r_count == '0);
  assign w_head  = r_q[r_rptr];
  assign w_push  = (r_state == S_IDLE) && w_any && !w_full;
  assign w_pop   = out_BUS_WVALID && in_BUS_WREADY && out_BUS_WLAST;

  always_comb begin
    int idx;
    idx   = 0;
    w_sel = '0;
    w_any = 1'b0;
`ifdef A_IO_M_AXI_WARB_PRIO0_EN
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (in_TOP_AWVALID[i]) begin
        w_sel = IDX_W'(i);
        w_any = 1'b1;
      end
    end
`else
    // Search starts one past the previous winner and wraps.
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = int'(r_last_grant) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!w_any && in_TOP_AWVALID[idx]) begin
        w_sel = IDX_W'(idx);
        w_any = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else if (clk_en) begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_push) w_next_state = S_ISSUE;
      S_ISSUE: if (in_BUS_AWREADY) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    out_TOP_AWREADY = '0;
    out_TOP_WREADY  = '0;
    out_BUS_AWVALID = (r_state == S_ISSUE);
    out_BUS_AWADDR  = r_awaddr;
    out_BUS_AWLEN   = r_awlen;
    out_BUS_WDATA   = '0;
    out_BUS_WSTRB   = '0;
    out_BUS_WLAST   = 1'b0;
    out_BUS_WVALID  = 1'b0;
    if (w_push) out_TOP_AWREADY[w_sel] = 1'b1;
    if (!w_empty) begin
      out_BUS_WDATA          = in_TOP_WDATA[int'(w_head)*DATA_WIDTH +: DATA_WIDTH];
      out_BUS_WSTRB          = in_TOP_WSTRB[int'(w_head)*SW +: SW];
      out_BUS_WLAST          = in_TOP_WLAST[w_head];
      out_BUS_WVALID         = in_TOP_WVALID[w_head];
      out_TOP_WREADY[w_head] = in_BUS_WREADY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= IDX_W'(NUM_PORTS - 1);
      r_awaddr     <= '0;
      r_awlen      <= '0;
    end else if (clk_en && w_push) begin
      r_last_grant <= w_sel;
      r_awaddr     <= in_TOP_AWADDR[int'(w_sel)*ADDR_WIDTH +: ADDR_WIDTH];
      r_awlen      <= in_TOP_AWLEN[int'(w_sel)*8 +: 8];
    end
  end

  // Order queue: granted port indices in AW issue order, popped on WLAST.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (clk_en) begin
      if (w_push) begin
        r_q[r_wptr] <= w_sel;
        r_wptr      <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_a_io_m_axi_write_arbiter.sv
// tb/tb_a_io_m_axi_write_arbiter.sv - vector table, directed sequences and random run against a queue-based model
module tb_a_io_m_axi_write_arbiter;
  localparam int NP = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int MQ = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, clk_en, bus_awready, bus_wready;
  logic [AW-1:0]    p_addr [NP];
  logic [7:0]       p_len [NP];
  logic [DW-1:0]    p_wdata [NP];
  logic [SW-1:0]    p_wstrb [NP];
  logic [NP-1:0]    p_awvalid, p_wvalid, p_wlast;

  logic [NP*AW-1:0] in_awaddr;
  logic [NP*8-1:0]  in_awlen;
  logic [NP*DW-1:0] in_wdata;
  logic [NP*SW-1:0] in_wstrb;
  logic [NP-1:0]    o_awready, o_wready;
  logic [AW-1:0]    o_awaddr;
  logic [7:0]       o_awlen;
  logic             o_awvalid, o_wlast, o_wvalid;
  logic [DW-1:0]    o_wdata;
  logic [SW-1:0]    o_wstrb;

  always_comb begin
    for (int i = 0; i < NP; i++) begin
      in_awaddr[i*AW +: AW] = p_addr[i];
      in_awlen[i*8 +: 8]    = p_len[i];
      in_wdata[i*DW +: DW]  = p_wdata[i];
      in_wstrb[i*SW +: SW]  = p_wstrb[i];
    end
  end

  a_io_m_axi_write_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAXREQS(MQ)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .in_TOP_AWADDR(in_awaddr), .in_TOP_AWLEN(in_awlen), .in_TOP_AWVALID(p_awvalid),
    .out_TOP_AWREADY(o_awready), .in_TOP_WDATA(in_wdata), .in_TOP_WSTRB(in_wstrb),
    .in_TOP_WLAST(p_wlast), .in_TOP_WVALID(p_wvalid), .out_TOP_WREADY(o_wready),
    .out_BUS_AWADDR(o_awaddr), .out_BUS_AWLEN(o_awlen), .out_BUS_AWVALID(o_awvalid),
    .in_BUS_AWREADY(bus_awready), .out_BUS_WDATA(o_wdata), .out_BUS_WSTRB(o_wstrb),
    .out_BUS_WLAST(o_wlast), .out_BUS_WVALID(o_wvalid), .in_BUS_WREADY(bus_wready)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: order queue of granted ports plus one pending bus AW.
  int            mq[$];
  int            m_last;
  bit            m_issue;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_len;
  int            m_sel;
  logic [NP-1:0] exp_awr, exp_wr;
  logic          exp_bwv, exp_bwl;
  logic [DW-1:0] exp_wd;
  logic [SW-1:0] exp_ws;

  function automatic int pick(input logic [NP-1:0] v);
`ifdef A_IO_M_AXI_WARB_PRIO0_EN
    for (int i = 0; i < NP; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= NP; k++) if (v[(m_last + k) % NP]) return (m_last + k) % NP;
`endif
    return -1;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_last  = NP - 1;
    m_issue = 0;
    m_addr  = '0;
    m_len   = '0;
  endtask

  task automatic model_eval();
    int h;
    exp_awr = '0;
    m_sel   = -1;
    if (!m_issue && mq.size() < MQ) begin
      m_sel = pick(p_awvalid);
      if (m_sel >= 0) exp_awr[m_sel] = 1'b1;
    end
    exp_wr = '0; exp_bwv = 0; exp_bwl = 0; exp_wd = '0; exp_ws = '0;
    if (mq.size() > 0) begin
      h = mq[0];
      exp_bwv   = p_wvalid[h];
      exp_bwl   = p_wlast[h];
      exp_wd    = p_wdata[h];
      exp_ws    = p_wstrb[h];
      exp_wr[h] = bus_wready;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
    chk("awready", o_awready, exp_awr);
    chk("wready", o_wready, exp_wr);
    chk("bus_awvalid", o_awvalid, m_issue);
    chk("bus_awaddr", o_awaddr, m_addr);
    chk("bus_awlen", o_awlen, m_len);
    chk("bus_wvalid", o_wvalid, exp_bwv);
    chk("bus_wlast", o_wlast, exp_bwl);
    chk("bus_wdata", o_wdata, exp_wd);
    chk("bus_wstrb", o_wstrb, exp_ws);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else if (clk_en) begin
      if (exp_bwv && bus_wready && exp_bwl) void'(mq.pop_front());
      if (m_issue) begin
        if (bus_awready) m_issue = 0;
      end else if (m_sel >= 0) begin
        mq.push_back(m_sel);
        m_issue = 1;
        m_addr  = p_addr[m_sel];
        m_len   = p_len[m_sel];
        m_last  = m_sel;
      end
    end
    #1;
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  task automatic idle_inputs();
    reset = 0; clk_en = 1; bus_awready = 1; bus_wready = 1;
    p_awvalid = '0; p_wvalid = '0; p_wlast = '0;
    for (int i = 0; i < NP; i++) begin
      p_addr[i]  = AW'(32'h100 * (i + 1));
      p_len[i]   = 8'd3;
      p_wdata[i] = DW'(32'hD000_0000 + i);
      p_wstrb[i] = SW'(4'hF - i);
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
    reset = 0;
  endtask

  typedef struct {
    logic rst; logic [NP-1:0] awv; logic [NP-1:0] wv; logic [NP-1:0] wl;
    logic bawr; logic bwr;
    logic [NP-1:0] e_awr; logic [NP-1:0] e_wr; logic e_bawv; logic [AW-1:0] e_addr;
    logic e_bwv; logic e_bwl;
  } vec_t;

  vec_t vecs [12];
  int   grants[$];
  int   cnt;

  initial begin
    vecs[0]  = '{1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'h000, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 2'b11, 2'b00, 2'b00, 1'b1, 1'b1, 2'b01, 2'b00, 1'b0, 32'h000, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 2'b10, 2'b10, 2'b00, 1'b1, 1'b1, 2'b00, 2'b01, 1'b1, 32'h100, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 2'b10, 2'b11, 2'b00, 1'b1, 1'b1, 2'b10, 2'b01, 1'b0, 32'h100, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 2'b00, 2'b11, 2'b00, 1'b1, 1'b1, 2'b00, 2'b01, 1'b1, 32'h200, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 2'b00, 2'b11, 2'b00, 1'b1, 1'b1, 2'b00, 2'b01, 1'b0, 32'h200, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 2'b00, 2'b11, 2'b01, 1'b1, 1'b1, 2'b00, 2'b01, 1'b0, 32'h200, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 2'b00, 2'b10, 2'b00, 1'b1, 1'b1, 2'b00, 2'b10, 1'b0, 32'h200, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 2'b00, 2'b10, 2'b00, 1'b1, 1'b1, 2'b00, 2'b10, 1'b0, 32'h200, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 2'b00, 2'b10, 2'b00, 1'b1, 1'b1, 2'b00, 2'b10, 1'b0, 32'h200, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 2'b00, 2'b10, 2'b10, 1'b1, 1'b1, 2'b00, 2'b10, 1'b0, 32'h200, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 2'b00, 2'b10, 2'b10, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 32'h200, 1'b0, 1'b0};

    idle_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    model_reset();
    #1;

    // Two-port grant order and W ordering behind port 0's WLAST.
    for (int i = 0; i < 12; i++) begin
      reset = vecs[i].rst; p_awvalid = vecs[i].awv; p_wvalid = vecs[i].wv; p_wlast = vecs[i].wl;
      bus_awready = vecs[i].bawr; bus_wready = vecs[i].bwr;
      settle();
      chk($sformatf("v%0d_awready", i), o_awready, vecs[i].e_awr);
      chk($sformatf("v%0d_wready", i), o_wready, vecs[i].e_wr);
      chk($sformatf("v%0d_bus_awvalid", i), o_awvalid, vecs[i].e_bawv);
      chk($sformatf("v%0d_bus_awaddr", i), o_awaddr, vecs[i].e_addr);
      chk($sformatf("v%0d_bus_wvalid", i), o_wvalid, vecs[i].e_bwv);
      chk($sformatf("v%0d_bus_wlast", i), o_wlast, vecs[i].e_bwl);
      tick();
    end

    // Queue full: four grants with W stalled, then one WLAST pop frees a slot.
    do_reset();
    bus_wready = 0; p_awvalid = 2'b11;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      settle();
      if (o_awready != '0) cnt++;
      tick();
    end
    chk("full_grant_count", cnt, 4);
    p_wvalid = 2'b11; p_wlast = 2'b11; bus_wready = 1;
    settle();
    chk("full_awready_blocked", o_awready, 2'b00);
    tick();
    p_wvalid = 2'b00; p_wlast = 2'b00; bus_wready = 0;
    settle();
    chk("after_pop_awready", o_awready, 2'b01);
    tick();

    // Bus AW stall holds address/length and blocks new grants.
    do_reset();
    bus_awready = 0; p_addr[0] = 32'h300; p_len[0] = 8'd7; p_awvalid = 2'b01;
    step();
    p_addr[0] = 32'h444; p_awvalid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("stall_awvalid", o_awvalid, 1'b1);
      chk("stall_awaddr", o_awaddr, 32'h300);
      chk("stall_awlen", o_awlen, 8'd7);
      chk("stall_awready", o_awready, 2'b00);
      tick();
    end
    bus_awready = 1;
    step();

    // Reset in the middle of a burst discards everything.
    do_reset();
    p_awvalid = 2'b01;
    step();
    p_awvalid = 2'b00; p_wvalid = 2'b01;
    step();
    step();
    reset = 1; p_wvalid = 2'b00;
    step();
    reset = 0; p_wvalid = 2'b01;
    settle();
    chk("rst_awvalid", o_awvalid, 1'b0);
    chk("rst_awaddr", o_awaddr, 32'h0);
    chk("rst_wvalid", o_wvalid, 1'b0);
    chk("rst_wready", o_wready, 2'b00);
    tick();
    p_wvalid = 2'b00; p_awvalid = 2'b11;
    settle();
    chk("rst_first_grant", o_awready, 2'b01);
    tick();

    // Continuous contention: alternation (or port-0 only with strict priority).
    do_reset();
    p_awvalid = 2'b11; p_wvalid = 2'b11; p_wlast = 2'b11;
    grants.delete();
    for (int i = 0; i < 8; i++) begin
      settle();
      if (o_awready != '0) grants.push_back(o_awready[1] ? 1 : 0);
      tick();
    end
    chk("alt_count", grants.size(), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++) begin
`ifdef A_IO_M_AXI_WARB_PRIO0_EN
      chk($sformatf("alt_grant%0d", i), grants[i], 0);
`else
      chk($sformatf("alt_grant%0d", i), grants[i], i % 2);
`endif
    end

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      reset       = ($urandom_range(0, 79) == 0);
      clk_en      = ($urandom_range(0, 3) != 0);
      bus_awready = ($urandom_range(0, 2) != 0);
      bus_wready  = ($urandom_range(0, 2) != 0);
      p_awvalid   = NP'($urandom);
      p_wvalid    = NP'($urandom);
      for (int i = 0; i < NP; i++) begin
        p_wlast[i] = ($urandom_range(0, 2) == 0);
        p_addr[i]  = $urandom;
        p_len[i]   = 8'($urandom);
        p_wdata[i] = $urandom;
        p_wstrb[i] = SW'($urandom);
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
